rf_wr_ctrl: RTL and testbench

Write-port controller for the 32×32 register file. After reset it runs a 31-cycle initialization sequence that loads each register with its own index. It then arbitrates the single RF write port between the CPU writeback stage and a debug/loader port. Writes are suppressed while the board freeze switch is active, and a starvation limit guarantees the debug port a slot.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_wr_ctrl_if.sv | 36 +++
 rtl/rf_wr_arb.sv | 49 ++++
 rtl/rf_wr_ctrl.sv | 117 +++++++++++
 tb/tb_rf_wr_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared sizes and types for the register-file write-port controller.
package rf_pkg;
    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;
    // One extra bit so the init counter can step past the top register.
    localparam int INIT_CW  = $clog2(RF_DEPTH) + 1;

    typedef enum logic {INIT, RUN} state_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_DBG} grant_e;

    function automatic logic [RF_DW-1:0] init_word(input logic [RF_AW-1:0] idx);
        return RF_DW'(idx);
    endfunction
endpackage

// File: rtl/rf_wr_ctrl_if.sv
// Request/response bundle between the write requesters and the RF write-port controller.
interface rf_wr_ctrl_if;
    import rf_pkg::*;

    logic             freeze;
    logic             wb_valid;
    logic [RF_AW-1:0] wb_addr;
    logic [RF_DW-1:0] wb_data;
    logic             wb_ready;
    logic             dbg_valid;
    logic [RF_AW-1:0] dbg_addr;
    logic [RF_DW-1:0] dbg_data;
    logic             dbg_ready;
    logic             rf_we;
    logic [RF_AW-1:0] rf_wa;
    logic [RF_DW-1:0] rf_wd;
    logic             init_done;

    modport slave (
        input  freeze,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        input  dbg_valid, dbg_addr, dbg_data,
        output dbg_ready,
        output rf_we, rf_wa, rf_wd, init_done
    );

    modport master (
        output freeze,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        output dbg_valid, dbg_addr, dbg_data,
        input  dbg_ready,
        input  rf_we, rf_wa, rf_wd, init_done
    );
endinterface

// File: rtl/rf_wr_arb.sv
// Write-port arbiter: CPU priority with a starvation override that forces a debug slot.
module rf_wr_arb
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   run,
    input  logic   freeze,
    input  logic   wb_valid,
    input  logic   dbg_valid,
    output grant_e grant
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       open;
    logic       starved;

    // Requests held during a reset cycle are not accepted, so nothing can slip past reset.
    assign open    = run && !rstn && !freeze;
    assign starved = (starve_cnt == LIMIT);

    always_comb begin
        grant = GNT_NONE;
        if (open) begin
            if (starved && dbg_valid) begin
                grant = GNT_DBG;
            end else if (wb_valid) begin
                grant = GNT_WB;
            end else if (dbg_valid) begin
                grant = GNT_DBG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            starve_cnt <= '0;
        end else if (grant == GNT_DBG) begin
            starve_cnt <= '0;
        end else if (run && !freeze && dbg_valid && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/rf_wr_ctrl.sv
// RF write-port controller: index-fill init sweep after reset, then CPU/debug arbitration.
// Define RF_WR_CTRL_TRACE_EN to print every RF write during simulation.
module rf_wr_ctrl
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rstn,
    rf_wr_ctrl_if.slave  bus
);

    // state | meaning
    // INIT  | writing r[i] = i for i = 1..31, requesters held off
    // RUN   | arbitrating CPU writeback and debug writes onto the RF port

    state_e             state;
    state_e             state_nxt;
    logic [INIT_CW-1:0] init_cnt;
    logic               init_last;
    grant_e             grant;
    logic               we_nxt;
    logic [RF_AW-1:0]   wa_nxt;
    logic [RF_DW-1:0]   wd_nxt;

    // init_cnt has walked past r31; the sweep cycle that follows writes nothing.
    assign init_last = init_cnt[INIT_CW-1];

    rf_wr_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .run       (state == RUN),
        .freeze    (bus.freeze),
        .wb_valid  (bus.wb_valid),
        .dbg_valid (bus.dbg_valid),
        .grant     (grant)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state    <= INIT;
            init_cnt <= INIT_CW'(1);
        end else begin
            state <= state_nxt;
            if (state == INIT && !init_last) begin
                init_cnt <= init_cnt + INIT_CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_last) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        bus.wb_ready  = (grant == GNT_WB);
        bus.dbg_ready = (grant == GNT_DBG);
        we_nxt        = 1'b0;
        wa_nxt        = bus.rf_wa;
        wd_nxt        = bus.rf_wd;
        case (state)
            INIT: begin
                if (!init_last) begin
                    we_nxt = 1'b1;
                    wa_nxt = init_cnt[RF_AW-1:0];
                    wd_nxt = init_word(init_cnt[RF_AW-1:0]);
                end
            end
            RUN: begin
                // x0 is hard-wired zero: accept the handshake but never strobe the RF.
                case (grant)
                    GNT_WB: begin
                        we_nxt = (bus.wb_addr != '0);
                        wa_nxt = bus.wb_addr;
                        wd_nxt = bus.wb_data;
                    end
                    GNT_DBG: begin
                        we_nxt = (bus.dbg_addr != '0);
                        wa_nxt = bus.dbg_addr;
                        wd_nxt = bus.dbg_data;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            bus.rf_we     <= 1'b0;
            bus.rf_wa     <= '0;
            bus.rf_wd     <= '0;
            bus.init_done <= 1'b0;
        end else begin
            bus.rf_we     <= we_nxt;
            bus.rf_wa     <= wa_nxt;
            bus.rf_wd     <= wd_nxt;
            bus.init_done <= (state_nxt == RUN);
        end
    end

`ifdef RF_WR_CTRL_TRACE_EN
    always @(posedge clk) begin
        if (bus.rf_we) begin
            $display("r[%2d] = 0x%8X,", bus.rf_wa, bus.rf_wd);
        end
    end
`else
`endif

endmodule

// File: tb/tb_rf_wr_ctrl.sv
// Randomized bench for rf_wr_ctrl against a cycle-count reference model.
`timescale 1ns/1ps
module tb_rf_wr_ctrl;
    import rf_pkg::*;

    localparam int LIMIT = 4;
    localparam int NPH   = 11;

    logic clk = 1'b0;
    logic rstn;

    rf_wr_ctrl_if bus();

    rf_wr_ctrl #(
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: edges since the last reset edge, and how long debug has waited.
    int          since = 0;
    int          waited = 0;
    bit          armed = 1'b0;
    bit          exp_we = 1'b0;
    bit          exp_done = 1'b0;
    logic [4:0]  exp_wa = '0;
    logic [31:0] exp_wd = '0;
    bit          wb_took = 1'b0;
    bit          dbg_took = 1'b0;

    // len, p_wb %, p_dbg %, p_freeze %, p_reset per-mille
    int ph_tab [NPH][5] = '{
        '{  3,   0,   0,   0, 1000},
        '{ 40,  50,  50,  50,    0},
        '{200,  40,  40,   0,    0},
        '{150, 100,  60,   0,    0},
        '{ 10, 100, 100, 100,    0},
        '{ 60, 100, 100,   0,    0},
        '{200,   0,  80,  10,    0},
        '{300, 100,  30,   0,   15},
        '{200,  60,  60,  30,    0},
        '{  2,   0,   0,   0, 1000},
        '{ 40,   0,   0,   0,    0}
    };

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'd0;
        return 5'($urandom_range(1, 31));
    endfunction

    task automatic step(input int p_wb, input int p_dbg, input int p_frz, input int p_rst);
        bit run_now;
        bit open;
        bit g_wb;
        bit g_dbg;
        @(negedge clk);
        cyc++;
        if (armed) begin
            chk_eq("rf_we",     bus.rf_we,     exp_we);
            chk_eq("rf_wa",     bus.rf_wa,     exp_wa);
            chk_eq("rf_wd",     bus.rf_wd,     exp_wd);
            chk_eq("init_done", bus.init_done, exp_done);
        end

        rstn       = ($urandom_range(0, 999) < p_rst);
        bus.freeze = ($urandom_range(0, 99) < p_frz);
        // A request not yet taken stays put; otherwise start a fresh one (or go idle).
        if (!(bus.wb_valid && !wb_took)) begin
            bus.wb_valid = ($urandom_range(0, 99) < p_wb);
            bus.wb_addr  = rnd_addr();
            bus.wb_data  = $urandom();
        end
        if (!(bus.dbg_valid && !dbg_took)) begin
            bus.dbg_valid = ($urandom_range(0, 99) < p_dbg);
            bus.dbg_addr  = rnd_addr();
            bus.dbg_data  = $urandom();
        end
        #1;

        run_now = !rstn && (since >= 32);
        open    = run_now && !bus.freeze;
        g_dbg   = open && bus.dbg_valid && (waited == LIMIT || !bus.wb_valid);
        g_wb    = open && bus.wb_valid && !g_dbg;
        if (armed) begin
            chk_eq("wb_ready",  bus.wb_ready,  g_wb);
            chk_eq("dbg_ready", bus.dbg_ready, g_dbg);
        end

        if (rstn) begin
            since    = 0;
            waited   = 0;
            exp_we   = 1'b0;
            exp_wa   = '0;
            exp_wd   = '0;
            exp_done = 1'b0;
            armed    = 1'b1;
        end else if (since < 32) begin
            since++;
            if (since <= 31) begin
                exp_we = 1'b1;
                exp_wa = 5'(since);
                exp_wd = 32'(since);
            end else begin
                exp_we   = 1'b0;
                exp_done = 1'b1;
            end
        end else begin
            if (g_wb) begin
                exp_we = (bus.wb_addr != 0);
                exp_wa = bus.wb_addr;
                exp_wd = bus.wb_data;
            end else if (g_dbg) begin
                exp_we = (bus.dbg_addr != 0);
                exp_wa = bus.dbg_addr;
                exp_wd = bus.dbg_data;
            end else begin
                exp_we = 1'b0;
            end
            if (g_dbg) begin
                waited = 0;
            end else if (bus.dbg_valid && !bus.freeze) begin
                waited = (waited < LIMIT) ? waited + 1 : LIMIT;
            end
        end
        wb_took  = g_wb;
        dbg_took = g_dbg;
    endtask

    initial begin
        rstn          = 1'b1;
        bus.freeze    = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.dbg_valid = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_data  = '0;
        for (int ph = 0; ph < NPH; ph++) begin
            for (int c = 0; c < ph_tab[ph][0]; c++) begin
                step(ph_tab[ph][1], ph_tab[ph][2], ph_tab[ph][3], ph_tab[ph][4]);
            end
        end
        @(negedge clk);
        chk_eq("final_rf_we",     bus.rf_we,     exp_we);
        chk_eq("final_init_done", bus.init_done, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
